stream_downsize: RTL and testbench
==================================

STREAM_DOWNSIZE -- requirements
Module: stream_downsize

Interface
REQ-001 SHALL have parameter T_DATA_WIDTH, default 32, width of one narrow output word in bits.
REQ-002 SHALL have parameter T_DATA_RATIO, default 4, number of narrow words per wide input beat (legal range 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port s_data_i  input  [T_DATA_WIDTH-1:0] x T_DATA_RATIO (unpacked array)  wide input beat; element 0 is sent first.
REQ-006 SHALL have port s_keep_i  input  T_DATA_RATIO  per-element valid mask.
REQ-007 SHALL have port s_last_i  input  1  wide beat ends a packet.
REQ-008 SHALL have port s_valid_i  input  1  input beat valid.
REQ-009 SHALL have port s_ready_o  output  1  block accepts input beat this cycle.
REQ-010 SHALL have port m_data_o  output  T_DATA_WIDTH  narrow output word.
REQ-011 SHALL have port m_last_o  output  1  word ends a packet.
REQ-012 SHALL have port m_valid_o  output  1  output word valid.
REQ-013 SHALL have port m_ready_i  input  1  downstream accepts word.

Function
REQ-014 SHALL transfer an input beat on a rising edge where s_valid_i and s_ready_o are both 1, and an output word where m_valid_o and m_ready_i are both 1.
REQ-015 SHALL capture the accepted beat's data, keep and last into a holding register; no other input storage.
REQ-016 SHALL use two states: IDLE (holding register empty) and SEND (at least one kept word still to be sent).
REQ-017 SHALL drive s_ready_o = 1 in IDLE, and in SEND only when the word currently presented is the last kept word and m_ready_i = 1 (combinational path, no bubble between beats).
REQ-018 SHALL emit kept words in ascending index order and skip elements with keep = 0, so an output word is never sent for a cleared keep bit.
REQ-019 SHALL assert m_valid_o on the first rising edge after acceptance, giving one cycle of latency from beat to first word.
REQ-020 SHALL drive m_valid_o, m_data_o and m_last_o from registers, and hold them stable while m_valid_o = 1 and m_ready_i = 0.
REQ-021 SHALL assert m_last_o only on the highest-index kept word of a beat that had s_last_i = 1; it SHALL be 0 on all other words.
REQ-022 SHALL, on an accepted beat with s_keep_i = 0, discard the beat, stay in IDLE with m_valid_o = 0, and drop its s_last_i.
REQ-023 SHALL, when the last kept word transfers and a new beat is accepted on the same edge, present the new beat's first kept word on the next cycle with m_valid_o held at 1.
REQ-024 SHALL, when the last kept word transfers with no new beat accepted, return to IDLE and deassert m_valid_o on the next cycle.
REQ-025 SHALL yield sustained throughput of one narrow word per cycle when s_valid_i and m_ready_i are held at 1.
REQ-026 SHALL NOT drop, duplicate or reorder words under any pattern of m_ready_i stalls.

Reset
REQ-027 SHALL, while rst_n = 0, force state to IDLE, m_valid_o = 0, m_last_o = 0, m_data_o = 0, keep register = 0, and s_ready_o = 0.
REQ-028 SHALL discard any partially sent beat on reset assertion mid-packet, and resume accepting beats in IDLE on the first rising edge after rst_n rises.

Structure
REQ-029 SHALL place the state enum (IDLE, SEND) in shared package stream_pkg, alongside the existing stream width and ratio defaults.
REQ-030 SHALL implement next-kept-index search as a sub-module stream_keep_next (keep mask plus current index gives next set index plus a "none left" flag).

Verification (T_DATA_WIDTH = 32, T_DATA_RATIO = 4)
REQ-031 SHALL check: beat {10,11,12,13}, keep 4'b1111, last 1, m_ready_i held 1 -> words 10,11,12,13 on four consecutive cycles, m_last_o = 1 only on 13.
REQ-032 SHALL check: beat {20,21,22,23}, keep 4'b1010, last 1 -> words 21,23 only, m_last_o = 1 on 23.
REQ-033 SHALL check: back-to-back beats {0..3} and {4..7}, all kept, both last 0 -> words 0..7 with no idle cycle, s_ready_o high on the cycles word 3 and word 7 are presented.
REQ-034 SHALL check: m_ready_i toggles 1,0,0,1,... during a beat -> m_data_o and m_last_o stay stable while stalled, and every word appears exactly once in order.
REQ-035 SHALL check: beat with keep 4'b0000, last 1 -> m_valid_o stays 0, the beat is consumed, and the next beat {30,31,32,33} keep 4'b0001 emits only 30.
REQ-036 SHALL check: rst_n pulsed low after word 1 of {40,41,42,43} -> m_valid_o = 0 immediately, no remaining words are emitted, and the next beat is sent normally.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared stream definitions: default data width / ratio, the downsizer
// FSM state enum, and a helper returning the highest set bit of a keep mask.
package stream_pkg;

   localparam int STREAM_DATA_WIDTH = 32;
   localparam int STREAM_DATA_RATIO = 4;

   typedef enum logic {
      IDLE = 1'b0,   // holding register empty
      SEND = 1'b1    // at least one kept word still to be sent
   } stream_state_e;

   // Highest set index of a keep mask (up to 16 elements); 0 for an empty mask.
   function automatic logic [3:0] hi_index(input logic [15:0] keep);
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (keep[i]) r = 4'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/stream_keep_next.sv
// Finds the lowest set keep bit at or above start_i.
//   keep_i  : keep mask
//   start_i : first index to consider (may equal RATIO, meaning nothing left)
//   idx_o   : lowest set index >= start_i (0 when none)
//   none_o  : no set bit at or above start_i
module stream_keep_next #(
   parameter int RATIO = 4,
   parameter int SW    = $clog2(RATIO),
   parameter int IW    = $clog2(RATIO + 1)
) (
   input  logic [RATIO-1:0] keep_i,
   input  logic [IW-1:0]    start_i,
   output logic [SW-1:0]    idx_o,
   output logic             none_o
);

   // Scan downwards so the lowest qualifying index wins.
   always_comb begin
      idx_o  = '0;
      none_o = 1'b1;
      for (int i = RATIO - 1; i >= 0; i--) begin
         if (keep_i[i] && (i >= int'(start_i))) begin
            idx_o  = SW'(i);
            none_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter. Accepts one beat of T_DATA_RATIO words
// into a holding register and emits the kept words one per cycle, element 0
// first, skipping cleared keep bits.
//   clk, rst_n              : clock, async active-low reset
//   s_data_i/keep/last/valid: wide input beat, s_ready_o handshake
//   m_data_o/last/valid     : registered narrow output word, m_ready_i handshake
module stream_downsize
   import stream_pkg::*;
#(
   parameter int T_DATA_WIDTH = STREAM_DATA_WIDTH,
   parameter int T_DATA_RATIO = STREAM_DATA_RATIO
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
   input  logic [T_DATA_RATIO-1:0] s_keep_i,
   input  logic                    s_last_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   output logic [T_DATA_WIDTH-1:0] m_data_o,
   output logic                    m_last_o,
   output logic                    m_valid_o,
   input  logic                    m_ready_i
);

   localparam int SW = $clog2(T_DATA_RATIO);
   localparam int IW = $clog2(T_DATA_RATIO + 1);

   stream_state_e           state_q, state_d;
   logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO];
   logic [T_DATA_WIDTH-1:0] data_d [T_DATA_RATIO];
   logic [T_DATA_RATIO-1:0] keep_q, keep_d;
   logic                    last_q, last_d;
   logic [SW-1:0]           idx_q, idx_d;   // index of the word being presented
   logic [SW-1:0]           hi_q, hi_d;     // highest kept index of held beat
   logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic                    m_last_q, m_last_d;
   logic                    m_valid_q, m_valid_d;

   logic [SW-1:0] first_idx, nxt_idx, hi_new;
   logic          first_none, nxt_none;
   logic          beat_in, last_word;

   // First kept word of the incoming beat.
   stream_keep_next #(.RATIO(T_DATA_RATIO)) u_first (
      .keep_i (s_keep_i),
      .start_i('0),
      .idx_o  (first_idx),
      .none_o (first_none)
   );

   // Next kept word after the one currently presented.
   stream_keep_next #(.RATIO(T_DATA_RATIO)) u_next (
      .keep_i (keep_q),
      .start_i(IW'(idx_q) + IW'(1)),
      .idx_o  (nxt_idx),
      .none_o (nxt_none)
   );

   assign hi_new    = SW'(hi_index(16'(s_keep_i)));
   assign last_word = (state_q == SEND) && nxt_none;
   // Take the next beat as the final kept word leaves, so beats run without a bubble.
   assign s_ready_o = rst_n && ((state_q == IDLE) || (last_word && m_ready_i));
   assign beat_in   = s_valid_i && s_ready_o;

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      keep_d    = keep_q;
      last_d    = last_q;
      idx_d     = idx_q;
      hi_d      = hi_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
      m_valid_d = m_valid_q;
      if (beat_in) begin
         data_d = s_data_i;
         keep_d = s_keep_i;
         last_d = s_last_i;
         idx_d  = first_idx;
         hi_d   = hi_new;
         if (first_none) begin
            // Empty beat: consumed and dropped, including its last flag.
            state_d   = IDLE;
            keep_d    = '0;
            last_d    = 1'b0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
         end else begin
            state_d   = SEND;
            m_valid_d = 1'b1;
            m_data_d  = s_data_i[first_idx];
            m_last_d  = s_last_i && (first_idx == hi_new);
         end
      end else if ((state_q == SEND) && m_ready_i) begin
         if (nxt_none) begin
            state_d   = IDLE;
            keep_d    = '0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
         end else begin
            idx_d    = nxt_idx;
            m_data_d = data_q[nxt_idx];
            m_last_d = last_q && (nxt_idx == hi_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         data_q    <= '{default: '0};
         keep_q    <= '0;
         last_q    <= 1'b0;
         idx_q     <= '0;
         hi_q      <= '0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         keep_q    <= keep_d;
         last_q    <= last_d;
         idx_q     <= idx_d;
         hi_q      <= hi_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         m_valid_q <= m_valid_d;
      end
   end

   assign m_data_o  = m_data_q;
   assign m_last_o  = m_last_q;
   assign m_valid_o = m_valid_q;

endmodule

// File: tb/tb_stream_downsize.sv
// Directed bench for stream_downsize (32-bit words, ratio 4).
module tb_stream_downsize;

   logic        clk;
   logic        rst_n;
   logic [31:0] s_data [4];
   logic [3:0]  s_keep;
   logic        s_last;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] m_data;
   logic        m_last;
   logic        m_valid;
   logic        m_ready;

   int checks = 0;
   int errors = 0;

   stream_downsize #(.T_DATA_WIDTH(32), .T_DATA_RATIO(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_data_i (s_data),
      .s_keep_i (s_keep),
      .s_last_i (s_last),
      .s_valid_i(s_valid),
      .s_ready_o(s_ready),
      .m_data_o (m_data),
      .m_last_o (m_last),
      .m_valid_o(m_valid),
      .m_ready_i(m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Check the presented word; data only matters while valid.
   task automatic expw(input string tag, input logic v, input logic [31:0] d, input logic l);
      chk({tag, ".valid"}, 32'(m_valid), 32'(v));
      chk({tag, ".last"},  32'(m_last),  32'(l));
      if (v) chk({tag, ".data"}, m_data, d);
   endtask

   task automatic beat(input logic [31:0] d0, d1, d2, d3, input logic [3:0] k, input logic l);
      s_data  = '{d0, d1, d2, d3};
      s_keep  = k;
      s_last  = l;
      s_valid = 1'b1;
   endtask

   initial begin
      logic [9:0] pat;
      int         k;
      rst_n   = 1'b0;
      s_data  = '{default: '0};
      s_keep  = '0;
      s_last  = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b1;

      // Reset state
      @(negedge clk);
      expw("rst", 1'b0, 32'd0, 1'b0);
      chk("rst.data", m_data, 32'd0);
      chk("rst.s_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("idle.s_ready", 32'(s_ready), 32'd1);

      // Full keep, last on 13
      beat(10, 11, 12, 13, 4'b1111, 1'b1);
      @(negedge clk); s_valid = 1'b0;
      expw("t1.w0", 1'b1, 10, 1'b0);
      chk("t1.w0.s_ready", 32'(s_ready), 32'd0);
      @(negedge clk); expw("t1.w1", 1'b1, 11, 1'b0);
      @(negedge clk); expw("t1.w2", 1'b1, 12, 1'b0);
      @(negedge clk); expw("t1.w3", 1'b1, 13, 1'b1);
      chk("t1.w3.s_ready", 32'(s_ready), 32'd1);
      @(negedge clk); expw("t1.idle", 1'b0, 0, 1'b0);

      // Sparse keep 1010
      beat(20, 21, 22, 23, 4'b1010, 1'b1);
      @(negedge clk); s_valid = 1'b0;
      expw("t2.w1", 1'b1, 21, 1'b0);
      @(negedge clk); expw("t2.w3", 1'b1, 23, 1'b1);
      @(negedge clk); expw("t2.idle", 1'b0, 0, 1'b0);

      // Back-to-back beats, no bubble
      beat(0, 1, 2, 3, 4'b1111, 1'b0);
      @(negedge clk);
      beat(4, 5, 6, 7, 4'b1111, 1'b0);
      expw("t3.w0", 1'b1, 0, 1'b0);
      @(negedge clk); expw("t3.w1", 1'b1, 1, 1'b0);
      @(negedge clk); expw("t3.w2", 1'b1, 2, 1'b0);
      @(negedge clk); expw("t3.w3", 1'b1, 3, 1'b0);
      chk("t3.w3.s_ready", 32'(s_ready), 32'd1);
      @(negedge clk); s_valid = 1'b0;
      expw("t3.w4", 1'b1, 4, 1'b0);
      chk("t3.w4.s_ready", 32'(s_ready), 32'd0);
      @(negedge clk); expw("t3.w5", 1'b1, 5, 1'b0);
      @(negedge clk); expw("t3.w6", 1'b1, 6, 1'b0);
      @(negedge clk); expw("t3.w7", 1'b1, 7, 1'b0);
      chk("t3.w7.s_ready", 32'(s_ready), 32'd1);
      @(negedge clk); expw("t3.idle", 1'b0, 0, 1'b0);

      // Stalls: m_ready pattern 1,0,0,1,0,0,1,0,0,1 (bit 0 first)
      beat(50, 51, 52, 53, 4'b1111, 1'b1);
      @(negedge clk); s_valid = 1'b0;
      pat = 10'b1001001001;
      k   = 0;
      for (int c = 0; c < 10; c++) begin
         expw($sformatf("t4.c%0d", c), 1'b1, 32'(50 + k), (k == 3));
         m_ready = pat[c];
         @(negedge clk);
         if (pat[c]) k++;
      end
      m_ready = 1'b1;
      chk("t4.count", 32'(k), 32'd4);
      expw("t4.idle", 1'b0, 0, 1'b0);

      // Empty keep is consumed; its last flag does not carry over
      beat(90, 91, 92, 93, 4'b0000, 1'b1);
      @(negedge clk);
      expw("t5.empty", 1'b0, 0, 1'b0);
      chk("t5.empty.s_ready", 32'(s_ready), 32'd1);
      beat(30, 31, 32, 33, 4'b0001, 1'b0);
      @(negedge clk); s_valid = 1'b0;
      expw("t5.w0", 1'b1, 30, 1'b0);
      @(negedge clk); expw("t5.idle", 1'b0, 0, 1'b0);

      // Reset mid-packet
      beat(40, 41, 42, 43, 4'b1111, 1'b1);
      @(negedge clk); s_valid = 1'b0;
      expw("t6.w0", 1'b1, 40, 1'b0);
      @(negedge clk); expw("t6.w1", 1'b1, 41, 1'b0);
      rst_n = 1'b0;
      #1;
      expw("t6.rst", 1'b0, 0, 1'b0);
      chk("t6.rst.data", m_data, 32'd0);
      chk("t6.rst.s_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); expw("t6.after", 1'b0, 0, 1'b0);
      chk("t6.after.s_ready", 32'(s_ready), 32'd1);
      beat(60, 61, 62, 63, 4'b0011, 1'b1);
      @(negedge clk); s_valid = 1'b0;
      expw("t6.n0", 1'b1, 60, 1'b0);
      @(negedge clk); expw("t6.n1", 1'b1, 61, 1'b1);
      @(negedge clk); expw("t6.idle", 1'b0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
